// File: rtl/rgmii_pkg.sv
// rgmii_pkg: shared states and line constants for the RGMII transmit sequencer
package rgmii_pkg;
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, DROP, PAD, IFG} state_t;
  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;
  localparam int TX_EN_BIT = 4;
  localparam int TX_ER_BIT = 4;
endpackage

// File: rtl/rgmii_ddr_encode.sv
// rgmii_ddr_encode: splits a byte plus TX_EN/TX_ER into rising and falling DDR words
module rgmii_ddr_encode
  import rgmii_pkg::*;
(
  input  logic [7:0] data,
  input  logic       en,
  input  logic       er,
  output logic [4:0] d1,
  output logic [4:0] d2
);
  // low nibble with TX_EN on the rising edge, high nibble with TX_EN^TX_ER on the falling edge
  always_comb begin
    d1 = {1'b0, data[3:0]};
    d1[TX_EN_BIT] = en;
    d2 = {1'b0, data[7:4]};
    d2[TX_ER_BIT] = en ^ er;
  end
endmodule

// File: rtl/rgmii_tx_sequencer.sv
// rgmii_tx_sequencer: frames a byte stream with preamble, padding, underflow error and IFG for RGMII TX
module rgmii_tx_sequencer
  import rgmii_pkg::*;
#(
  parameter int PREAMBLE_BYTES  = 7,
  parameter int MIN_FRAME_BYTES = 60,
  parameter int IFG_BYTES       = 12,
  parameter int CNT_WIDTH       = 11
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [4:0] tx_d1,
  output logic [4:0] tx_d2,
  output logic       busy,
  output logic       frame_done,
  output logic       underflow
);
  localparam logic [CNT_WIDTH-1:0] PRE_LAST = CNT_WIDTH'(PREAMBLE_BYTES - 1);
  localparam logic [CNT_WIDTH-1:0] MIN_LEN  = CNT_WIDTH'(MIN_FRAME_BYTES);
  localparam logic [CNT_WIDTH-1:0] IFG_LAST = CNT_WIDTH'(IFG_BYTES - 1);

  state_t state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n, cnt_inc;
  logic [7:0] byte_n;
  logic en_n, er_n;
  logic [4:0] d1_n, d2_n;

  assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
  assign s_ready = state == DATA || state == DROP;
  assign busy = state != IDLE;

  // next state, counter and the byte/control presented to the encoder this cycle
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    byte_n = 8'h00;
    en_n = 1'b0;
    er_n = 1'b0;
    case (state)
      IDLE: begin
        state_n = s_valid ? PRE : IDLE;
        cnt_n = '0;
      end
      PRE: begin
        byte_n = PREAMBLE_BYTE;
        en_n = 1'b1;
        state_n = cnt == PRE_LAST ? SFD : PRE;
        cnt_n = cnt == PRE_LAST ? '0 : cnt_inc;
      end
      SFD: begin
        byte_n = SFD_BYTE;
        en_n = 1'b1;
        state_n = DATA;
        cnt_n = '0;
      end
      DATA: begin
        en_n = 1'b1;
        er_n = !s_valid;
        byte_n = s_valid ? s_data : 8'h00;
        if (!s_valid) state_n = DROP;
        else if (s_last) begin
          state_n = cnt_inc < MIN_LEN ? PAD : IFG;
          cnt_n = cnt_inc < MIN_LEN ? cnt_inc : '0;
        end else cnt_n = cnt_inc;
      end
      DROP: begin
        state_n = s_valid && s_last ? IFG : DROP;
        cnt_n = '0;
      end
      PAD: begin
        en_n = 1'b1;
        state_n = cnt_inc >= MIN_LEN ? IFG : PAD;
        cnt_n = cnt_inc >= MIN_LEN ? '0 : cnt_inc;
      end
      IFG: begin
        state_n = cnt == IFG_LAST ? IDLE : IFG;
        cnt_n = cnt == IFG_LAST ? '0 : cnt_inc;
      end
      default: begin
        state_n = IDLE;
        cnt_n = '0;
      end
    endcase
  end

  rgmii_ddr_encode u_enc (
    .data(byte_n),
    .en  (en_n),
    .er  (er_n),
    .d1  (d1_n),
    .d2  (d2_n)
  );

  // state, counter and registered DDR words plus status pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      tx_d1 <= '0;
      tx_d2 <= '0;
      frame_done <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      tx_d1 <= d1_n;
      tx_d2 <= d2_n;
      frame_done <= state_n == IFG && state != IFG;
      underflow <= state == DATA && !s_valid;
    end
  end
endmodule

// File: tb/tb_rgmii_tx_sequencer.sv
// tb_rgmii_tx_sequencer: scoreboard bench for the RGMII transmit sequencer
module tb_rgmii_tx_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0;
  logic s_last = 1'b0;
  logic s_ready, busy, frame_done, underflow;
  logic [4:0] tx_d1, tx_d2;

  int total = 0;
  int bad = 0;
  int run = 0, last_run = 0, gap = 0, last_gap = 0;
  int fd_cnt = 0, uf_cnt = 0;
  logic [9:0] exp_q[$];

  rgmii_tx_sequencer dut (
    .clock     (clk),
    .reset     (reset),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .tx_d1     (tx_d1),
    .tx_d2     (tx_d2),
    .busy      (busy),
    .frame_done(frame_done),
    .underflow (underflow)
  );

  always #4 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] w(input logic [7:0] b, input logic er);
    return {1'b1, b[3:0], ~er, b[7:4]};
  endfunction

  // monitor: every TX_EN cycle pops one expected word; idle cycles must be all-zero
  always @(negedge clk) begin
    if (tx_d1[4] === 1'b1) begin
      run++;
      if (gap > 0) last_gap = gap;
      gap = 0;
      if (exp_q.size() == 0) chk("extra_word", {tx_d1, tx_d2}, 32'hFFFF);
      else chk("word", {tx_d1, tx_d2}, exp_q.pop_front());
    end else begin
      gap++;
      if (run > 0) last_run = run;
      run = 0;
      chk("idle_word", {tx_d1, tx_d2}, 0);
    end
    if (frame_done) fd_cnt++;
    if (underflow) uf_cnt++;
  end

  task automatic send_byte(input logic [7:0] b, input logic l);
    int t;
    t = 0;
    s_data = b;
    s_last = l;
    s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      t++;
      if (t > 1000) begin
        chk("hs_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_head();
    for (int i = 0; i < 7; i++) exp_q.push_back(w(8'h55, 1'b0));
    exp_q.push_back(w(8'hD5, 1'b0));
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input int uf_at);
    push_head();
    for (int i = 0; i < n && (uf_at == 0 || i < uf_at); i++) exp_q.push_back(w(base + 8'(i), 1'b0));
    if (uf_at != 0) exp_q.push_back(10'h200);
    else for (int k = n; k < 60; k++) exp_q.push_back(10'h210);
    for (int i = 0; i < n; i++) begin
      if (uf_at != 0 && i == uf_at) begin
        s_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_byte(base + 8'(i), i == n - 1);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 || tx_d1[4]) begin
      @(negedge clk);
      t++;
      if (t > 2000) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
    repeat (16) @(negedge clk);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_idle", {s_ready, busy, frame_done, underflow, tx_d1, tx_d2}, 0);
    end

    send_frame(64, 8'h00, 0);
    drain();
    chk("run_64", last_run, 72);
    chk("fd_64", fd_cnt, 1);

    send_frame(10, 8'h80, 0);
    drain();
    chk("run_pad", last_run, 68);
    chk("fd_pad", fd_cnt, 2);

    send_frame(8, 8'h40, 5);
    drain();
    chk("run_uf", last_run, 14);
    chk("uf_cnt", uf_cnt, 1);
    chk("fd_uf", fd_cnt, 3);

    send_frame(60, 8'h10, 0);
    send_frame(60, 8'hC0, 0);
    drain();
    chk("b2b_gap", last_gap, 13);
    chk("b2b_run", last_run, 68);
    chk("fd_b2b", fd_cnt, 5);

    push_head();
    for (int i = 0; i < 30; i++) exp_q.push_back(w(8'h20 + 8'(i), 1'b0));
    for (int i = 0; i < 30; i++) send_byte(8'h20 + 8'(i), 1'b0);
    reset = 1'b1;
    s_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_out", {tx_d1, tx_d2}, 0);
    chk("mid_rst_st", {s_ready, busy}, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    send_frame(20, 8'hA0, 0);
    drain();
    chk("run_after_rst", last_run, 68);
    chk("fd_final", fd_cnt, 6);
    chk("uf_final", uf_cnt, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
